// File: rtl/adc_ctrl_pkg.sv
// adc_ctrl_pkg: shared types and defaults for the ADC frame sequencer
package adc_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_EDGE, SETTLE, CAPTURE} seq_state_t;
    localparam int M_SAMPLES_DEF = 512;
    localparam int IDX_W_DEF = 9;
endpackage

// File: rtl/cdc_edge_sync.sv
// cdc_edge_sync: multi-flop synchroniser with a one-cycle rising-edge pulse
//   clk, rst  : system clock, synchronous active-high reset
//   async_in  : signal asynchronous to clk
//   pulse     : high for one cycle per synchronised rising edge of async_in
module cdc_edge_sync #(
    parameter int SYNC_STAGES = 2
)(
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse
);
    // sr[SYNC_STAGES-1] is the synchronised value, sr[SYNC_STAGES] its previous cycle
    logic [SYNC_STAGES:0] sr;
    always_ff @(posedge clk) begin
        if (rst)
            sr <= '0;
        else
            sr <= {sr[SYNC_STAGES-1:0], async_in};
    end
    assign pulse = sr[SYNC_STAGES-1] & ~sr[SYNC_STAGES];
endmodule

// File: rtl/adc_frame_sequencer.sv
// adc_frame_sequencer: captures ADC samples into a double-buffered frame store and hands frames downstream
//   clk, rst     : system clock, synchronous active-high reset
//   enable       : run request; low returns to IDLE and discards a partial frame
//   CASCOUT      : asynchronous ADC conversion-complete strobe
//   cap_en       : one-cycle write strobe, qualified by wr_bank / wr_idx
//   frame_ready  : bank rd_bank holds a full frame
//   frame_ack    : consumer releases bank rd_bank
//   overrun      : sticky dropped-sample flag, cleared on leaving IDLE
//   frame_count  : completed frames, wrapping
module adc_frame_sequencer
    import adc_ctrl_pkg::*;
#(
    parameter int M_SAMPLES = M_SAMPLES_DEF,
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES = 2,
    localparam int IDX_W = $clog2(M_SAMPLES)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             CASCOUT,
    output logic             cap_en,
    output logic             wr_bank,
    output logic [IDX_W-1:0] wr_idx,
    output logic             frame_ready,
    output logic             rd_bank,
    input  logic             frame_ack,
    output logic             overrun,
    output logic [15:0]      frame_count
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(M_SAMPLES - 1);

    seq_state_t state, state_nxt;
    logic [CW-1:0] settle_cnt;
    logic [1:0] bank_full, bank_full_nxt;
    logic casc_rise, drop, fill, ack, rd_nxt;

    cdc_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk),
        .rst(rst),
        .async_in(CASCOUT),
        .pulse(casc_rise)
    );

    always_comb begin
        state_nxt = state;
        drop = 1'b0;
        case (state)
            IDLE: state_nxt = WAIT_EDGE;
            WAIT_EDGE: if (casc_rise) begin
                drop = bank_full[wr_bank];
                state_nxt = bank_full[wr_bank] ? WAIT_EDGE : SETTLE;
            end
            SETTLE: begin
                drop = casc_rise;
                state_nxt = settle_cnt == '0 ? CAPTURE : SETTLE;
            end
            default: begin
                drop = casc_rise;
                state_nxt = WAIT_EDGE;
            end
        endcase
        if (!enable) state_nxt = IDLE;
        cap_en = state == CAPTURE;
        fill = cap_en && enable && wr_idx == LAST;
        ack = frame_ack && frame_ready;
        rd_nxt = rd_bank ^ ack;
        bank_full_nxt = bank_full;
        if (ack) bank_full_nxt[rd_bank] = 1'b0;
        if (fill) bank_full_nxt[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            settle_cnt <= '0;
            wr_idx <= '0;
            wr_bank <= 1'b0;
            bank_full <= 2'b00;
            rd_bank <= 1'b0;
            frame_ready <= 1'b0;
            overrun <= 1'b0;
            frame_count <= '0;
        end else begin
            state <= state_nxt;
            settle_cnt <= (state_nxt == SETTLE && state != SETTLE) ? CW'(SETTLE_CYCLES - 1) : settle_cnt - CW'(1);
            overrun <= (state == IDLE && state_nxt == WAIT_EDGE) ? 1'b0 : overrun | drop;
            wr_idx <= !enable ? '0 : wr_idx + IDX_W'(cap_en);
            wr_bank <= wr_bank ^ fill;
            frame_count <= frame_count + 16'(fill);
            bank_full <= bank_full_nxt;
            rd_bank <= rd_nxt;
            // registered from next-state values so an acked bank never shows ready again
            frame_ready <= bank_full_nxt[rd_nxt];
        end
    end
endmodule

// File: tb/tb_adc_frame_sequencer.sv
// tb_adc_frame_sequencer: directed and random stimulus checked against a behavioural frame-store model
module tb_adc_frame_sequencer;
    localparam int M = 8;
    localparam int ST = 4;

    logic clk = 0, rst = 0, enable = 0, CASCOUT = 0, frame_ack = 0;
    logic cap_en, wr_bank, frame_ready, rd_bank, overrun;
    logic [2:0] wr_idx;
    logic [15:0] frame_count;

    adc_frame_sequencer #(.M_SAMPLES(M), .SETTLE_CYCLES(ST), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .enable(enable), .CASCOUT(CASCOUT),
        .cap_en(cap_en), .wr_bank(wr_bank), .wr_idx(wr_idx),
        .frame_ready(frame_ready), .rd_bank(rd_bank), .frame_ack(frame_ack),
        .overrun(overrun), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0, n_caps = 0;

    // model: run mode, scheduled capture cycle, CASCOUT history and bank bookkeeping
    int m_cyc = 0, m_cap_at = -1, m_idx = 0, m_count = 0;
    bit m_active = 0, m_bank = 0, m_rd = 0, m_ready = 0, m_over = 0;
    bit [2:0] m_h = 0;
    bit [1:0] m_full = 0;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic m_reset();
        m_cap_at = -1; m_idx = 0; m_count = 0; m_active = 0; m_bank = 0;
        m_rd = 0; m_ready = 0; m_over = 0; m_h = 0; m_full = 0; m_cyc++;
    endtask

    task automatic m_edge(input bit e, input bit a, input bit c);
        bit rise, cap;
        int nc;
        rise = m_h[1] && !m_h[2];
        cap = m_active && m_cap_at == m_cyc;
        nc = -1;
        if (m_active && rise) begin
            if (m_cap_at >= m_cyc || m_full[m_bank]) m_over = 1;
            else nc = m_cyc + ST + 1;
        end
        if (a && m_ready) begin
            m_full[m_rd] = 0;
            m_rd = !m_rd;
        end
        if (cap && e) begin
            if (m_idx == M - 1) begin
                m_full[m_bank] = 1;
                m_bank = !m_bank;
                m_count = (m_count + 1) % 65536;
                m_idx = 0;
            end else m_idx++;
        end
        if (!e) begin
            m_idx = 0;
            m_cap_at = -1;
        end else begin
            if (!m_active) m_over = 0;
            if (nc >= 0) m_cap_at = nc;
        end
        m_ready = m_full[m_rd];
        m_h = {m_h[1:0], c};
        m_active = e;
        m_cyc++;
    endtask

    task automatic tick(input logic r, input logic e, input logic a, input logic c);
        rst = r; enable = e; frame_ack = a; CASCOUT = c;
        @(posedge clk);
        if (r) m_reset(); else m_edge(e, a, c);
        #1;
        check("cap_en", cap_en, m_active && m_cap_at == m_cyc);
        check("wr_idx", wr_idx, m_idx[2:0]);
        check("wr_bank", wr_bank, m_bank);
        check("frame_ready", frame_ready, m_ready);
        check("rd_bank", rd_bank, m_rd);
        check("overrun", overrun, m_over);
        check("frame_count", frame_count, m_count[15:0]);
        if (cap_en === 1'b1) n_caps++;
    endtask

    task automatic pulse();
        for (int i = 0; i < 10; i++) tick(0, 1, 0, i < 2);
    endtask

    initial begin
        int c0;
        bit cv, ev;
        for (int i = 0; i < 3; i++) tick(1, 1, 0, i[0]);
        check("lit_rst_cap", cap_en, 0);
        check("lit_rst_ready", frame_ready, 0);
        check("lit_rst_count", frame_count, 0);
        check("lit_rst_ovr", overrun, 0);
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 0);
        c0 = n_caps;
        for (int i = 1; i <= 6; i++) tick(0, 1, 0, i <= 2);
        check("lit_lat_early", n_caps, c0);
        tick(0, 1, 0, 0);
        check("lit_lat_cap", cap_en, 1);
        check("lit_lat_idx", wr_idx, 0);
        check("lit_lat_bank", wr_bank, 0);
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 0);
        for (int i = 0; i < 7; i++) pulse();
        check("lit_fr_ready", frame_ready, 1);
        check("lit_fr_rd", rd_bank, 0);
        check("lit_fr_wb", wr_bank, 1);
        check("lit_fr_count", frame_count, 1);
        tick(0, 1, 1, 0);
        check("lit_ack_ready", frame_ready, 0);
        check("lit_ack_rd", rd_bank, 1);
        for (int i = 0; i < 16; i++) pulse();
        check("lit_full_count", frame_count, 3);
        c0 = n_caps;
        pulse();
        check("lit_ovr_nocap", n_caps, c0);
        check("lit_ovr_set", overrun, 1);
        tick(0, 1, 1, 0);
        pulse();
        check("lit_after_ack_cap", n_caps, c0 + 1);
        for (int i = 0; i < 2; i++) tick(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) tick(0, 1, 0, 0);
        check("lit_reen_ovr", overrun, 0);
        c0 = n_caps;
        for (int i = 0; i < 14; i++) tick(0, 1, 0, i == 0 || i == 1 || i == 3 || i == 4);
        check("lit_settle_one_cap", n_caps, c0 + 1);
        check("lit_settle_ovr", overrun, 1);
        for (int i = 0; i < 4; i++) pulse();
        check("lit_idx5", wr_idx, 5);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
        for (int i = 0; i < 2; i++) tick(0, 1, 0, 0);
        check("lit_drop_idx", wr_idx, 0);
        check("lit_drop_bank", wr_bank, 1);
        check("lit_drop_ovr", overrun, 0);
        pulse();
        check("lit_drop_next", wr_idx, 1);
        for (int i = 0; i < 2; i++) tick(1, 0, 0, 0);
        for (int i = 0; i < 2; i++) tick(0, 1, 0, 0);
        for (int i = 0; i < 15; i++) pulse();
        for (int i = 0; i < 10; i++) tick(0, 1, m_active && m_cap_at == m_cyc, i < 2);
        check("lit_sim_ready", frame_ready, 1);
        check("lit_sim_rd", rd_bank, 1);
        check("lit_sim_count", frame_count, 2);
        cv = 0;
        ev = 1;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(5) == 0) cv = !cv;
            if ($urandom_range(300) == 0) ev = !ev;
            else if (!ev && $urandom_range(3) == 0) ev = 1;
            tick($urandom_range(1500) == 0, ev, $urandom_range(9) == 0, cv);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
